// File: rtl/mul_cell_pipe.sv
// mul_cell_pipe: pipelined multiplier cell with valid/ready handshake,
// low-half MUL and signed/unsigned high-half MULX variants.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   reset      - asynchronous active-high reset, clears every valid bit
//   in_valid   - operands and op presented
//   in_ready   - request can be accepted this cycle
//   src1       - multiplicand (DATA_W)
//   src2       - multiplier (DATA_W)
//   op         - 00 MUL low, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   flush      - synchronous discard of every in-flight request
//   out_valid  - result is valid
//   out_ready  - consumer takes the result
//   result     - selected product half (DATA_W)
//   busy       - some pipeline stage holds a valid request
module mul_cell_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        op,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    localparam int unsigned EXT_W  = DATA_W + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;

    logic [LATENCY-1:0]       stage_vld;
    logic [DATA_W-1:0]        stage_res [LATENCY];

    logic                     advance;
    logic                     accept;
    logic                     sign1;
    logic                     sign2;
    logic signed [EXT_W-1:0]  opa;
    logic signed [EXT_W-1:0]  opb;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        head_res;

    // Whole pipeline moves as one unit; only a held output blocks it.
    always_comb begin
        advance = !(stage_vld[LATENCY-1] && !out_ready);
        accept  = in_valid && advance && !flush;
    end

    // Operand extension to DATA_W+1 bits makes one signed multiplier cover
    // all four ops. Only the low 2*DATA_W product bits are ever selected,
    // so the product is computed modulo 2^(2*DATA_W).
    always_comb begin
        sign1    = (op == OP_MULXSS) || (op == OP_MULXSU);
        sign2    = (op == OP_MULXSS);
        opa      = {sign1 & src1[DATA_W-1], src1};
        opb      = {sign2 & src2[DATA_W-1], src2};
        prod     = PROD_W'(opa) * PROD_W'(opb);
        head_res = (op == OP_MUL) ? prod[DATA_W-1:0] : prod[PROD_W-1:DATA_W];
    end

    // Stage valid bits and result registers; the multiplier output feeds the
    // register chain directly so the tool can absorb stages into the DSP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_res[i] <= '0;
            end
        end else begin
            if (flush) begin
                stage_vld <= '0;
            end else if (advance) begin
                stage_vld[0] <= in_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    stage_vld[i] <= stage_vld[i-1];
                end
            end
            // Data only moves behind a valid request so idle cycles keep
            // the last delivered result on the output.
            if (advance) begin
                if (accept) begin
                    stage_res[0] <= head_res;
                end
                for (int i = 1; i < LATENCY; i++) begin
                    if (stage_vld[i-1]) begin
                        stage_res[i] <= stage_res[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = stage_vld[LATENCY-1];
    assign result    = stage_res[LATENCY-1];
    assign busy      = |stage_vld;

endmodule

// File: tb/tb_mul_cell_pipe.sv
// tb_mul_cell_pipe: directed and randomised checks of mul_cell_pipe.
// Instances: u_dut (32/2, directed target), u_l1 (32/1), u_l4 (32/4),
// u_w16 (16/2). All share the same stimulus; a per-instance scoreboard
// with an independent 64-bit reference model checks every delivered result.
// Latency is counted from the cycle in which a request is accepted.
module tb_mul_cell_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;

    logic [3:0]  ov;
    logic [3:0]  ir;
    logic [3:0]  bz;
    logic [31:0] res0;
    logic [31:0] res1;
    logic [31:0] res2;
    logic [15:0] res3;

    int total = 0;
    int bad   = 0;

    // Scoreboard: circular buffers of expected results per instance.
    logic [31:0] exp_mem [4][256];
    logic [7:0]  wr [4];
    logic [7:0]  rd [4];
    int          wdt [4];

    always #5 clk = ~clk;

    mul_cell_pipe #(.DATA_W(32), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .src1(src1), .src2(src2), .op(op), .flush(flush),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res0), .busy(bz[0])
    );

    mul_cell_pipe #(.DATA_W(32), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .src1(src1), .src2(src2), .op(op), .flush(flush),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res1), .busy(bz[1])
    );

    mul_cell_pipe #(.DATA_W(32), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
        .src1(src1), .src2(src2), .op(op), .flush(flush),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res2), .busy(bz[2])
    );

    mul_cell_pipe #(.DATA_W(16), .LATENCY(2)) u_w16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]),
        .src1(src1[15:0]), .src2(src2[15:0]), .op(op), .flush(flush),
        .out_valid(ov[3]), .out_ready(out_ready), .result(res3), .busy(bz[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_res(input int k);
        case (k)
            0:       got_res = res0;
            1:       got_res = res1;
            2:       got_res = res2;
            default: got_res = {16'h0, res3};
        endcase
    endfunction

    // Reference: extend operands to 64 bits, multiply, pick the half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] o, input int w);
        logic [63:0] m;
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] p;
        m   = (64'd1 << w) - 64'd1;
        a64 = {32'h0, a} & m;
        b64 = {32'h0, b} & m;
        if ((o == 2'd1 || o == 2'd2) && a64[w-1]) a64 = a64 | ~m;
        if (o == 2'd1 && b64[w-1]) b64 = b64 | ~m;
        p = a64 * b64;
        if (o == 2'd0) ref_mul = 32'(p & m);
        else           ref_mul = 32'((p >> w) & m);
    endfunction

    // Scoreboard update, evaluated mid-cycle with stable inputs.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                rd[k] = wr[k];
            end else begin
                if (ov[k] && out_ready) begin
                    check($sformatf("sb%0d_pending", k), 32'(wr[k] != rd[k]), 32'd1);
                    if (wr[k] != rd[k]) begin
                        check($sformatf("sb%0d_res", k), got_res(k), exp_mem[k][rd[k]]);
                        rd[k] = rd[k] + 8'd1;
                    end
                end
                if (flush) begin
                    rd[k] = wr[k];
                end else if (in_valid && ir[k]) begin
                    exp_mem[k][wr[k]] = ref_mul(src1, src2, op, wdt[k]);
                    wr[k] = wr[k] + 8'd1;
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // Four requests back to back on u_dut, results expected in cycles 2..5.
    task automatic burst4(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0][1:0] ops, input logic [3:0][31:0] exps,
                          input string name);
        for (int c = 0; c < 7; c++) begin
            next_cycle;
            in_valid  = (c < 4);
            if (c < 4) op = ops[c];
            src1      = a;
            src2      = b;
            out_ready = 1'b1;
            sample;
            check({name, "_vld"}, 32'(ov[0]), 32'((c >= 2) && (c < 6)));
            if (c >= 2 && c < 6) check({name, "_res"}, res0, exps[c-2]);
        end
    endtask

    initial begin
        int i;
        int n;
        logic [31:0] prev;
        logic stalled_prev;

        wdt[0] = 32; wdt[1] = 32; wdt[2] = 32; wdt[3] = 16;
        for (int k = 0; k < 4; k++) begin
            wr[k] = 8'd0;
            rd[k] = 8'd0;
        end
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = 2'd0; src1 = '0; src2 = '0;

        // Reset state
        repeat (2) sample;
        check("rst_ovalid", 32'(ov[0]), 32'd0);
        check("rst_busy",   32'(bz[0]), 32'd0);
        check("rst_iready", 32'(ir[0]), 32'd1);
        check("rst_result", res0, 32'd0);

        // First accept on the first edge after release: 3*4=12
        next_cycle;
        reset = 1'b0; in_valid = 1'b1; src1 = 32'd3; src2 = 32'd4; op = 2'd0;
        sample;
        check("rel_iready", 32'(ir[0]), 32'd1);
        next_cycle;
        in_valid = 1'b0;
        sample;
        check("rel_c1_vld",  32'(ov[0]), 32'd0);
        check("rel_c1_busy", 32'(bz[0]), 32'd1);
        next_cycle;
        sample;
        check("rel_c2_vld", 32'(ov[0]), 32'd1);
        check("rel_c2_res", res0, 32'd12);
        next_cycle;
        sample;
        check("rel_c3_vld", 32'(ov[0]), 32'd0);

        // All four ops on all-ones operands
        burst4(32'hFFFF_FFFF, 32'hFFFF_FFFF, {2'd3, 2'd2, 2'd1, 2'd0},
               {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001}, "ops");

        // Most-negative operands, op order 01,10,11,00
        burst4(32'h8000_0000, 32'h8000_0000, {2'd0, 2'd3, 2'd2, 2'd1},
               {32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000}, "sgn");

        // Back-pressure: 8 requests i*3 x 7, out_ready low in cycles 3..5
        i = 0; n = 0; prev = '0; stalled_prev = 1'b0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            next_cycle;
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (i < 8);
            src1      = 32'(3 * i);
            src2      = 32'd7;
            op        = 2'd0;
            sample;
            check("bp_iready", 32'(ir[0]), 32'(!(ov[0] && !out_ready)));
            if (stalled_prev) check("bp_hold", res0, prev);
            if (ov[0] && out_ready) begin
                check("bp_res", res0, 32'(21 * n));
                n++;
            end
            stalled_prev = ov[0] && !out_ready;
            prev = res0;
            if (in_valid && ir[0]) i++;
        end
        check("bp_count", 32'(n), 32'd8);
        next_cycle;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) next_cycle;

        // Flush during a stall with two in flight and one offered
        in_valid = 1'b1; src1 = 32'd5; src2 = 32'd6; op = 2'd0; out_ready = 1'b0;
        sample;
        next_cycle;
        src1 = 32'd7; src2 = 32'd8;
        sample;
        check("fl_accept_b", 32'(ir[0]), 32'd1);
        next_cycle;
        src1 = 32'd9; src2 = 32'd10; flush = 1'b1;
        sample;
        check("fl_pre_vld",  32'(ov[0]), 32'd1);
        check("fl_pre_busy", 32'(bz[0]), 32'd1);
        next_cycle;
        // Flush again while idle with a request offered: it must be dropped
        src1 = 32'd1; src2 = 32'd2; out_ready = 1'b1;
        sample;
        check("fl_post_vld",  32'(ov[0]), 32'd0);
        check("fl_post_busy", 32'(bz[0]), 32'd0);
        check("fl_iready",    32'(ir[0]), 32'd1);
        next_cycle;
        flush = 1'b0; src1 = 32'd11; src2 = 32'd12;
        sample;
        check("fl_drop_busy", 32'(bz[0]), 32'd0);
        check("fl_drop_vld",  32'(ov[0]), 32'd0);
        next_cycle;
        in_valid = 1'b0;
        sample;
        check("fl_d_c1_vld", 32'(ov[0]), 32'd0);
        next_cycle;
        sample;
        check("fl_d_vld", 32'(ov[0]), 32'd1);
        check("fl_d_res", res0, 32'd132);
        next_cycle;
        sample;
        check("fl_d_end", 32'(ov[0]), 32'd0);

        // Asynchronous reset with two in flight
        next_cycle;
        in_valid = 1'b1; src1 = 32'd13; src2 = 32'd2; out_ready = 1'b1;
        next_cycle;
        src1 = 32'd17;
        next_cycle;
        in_valid = 1'b0;
        #2;
        check("ar_pre_vld",  32'(ov[0]), 32'd1);
        check("ar_pre_busy", 32'(bz[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_vld",    32'(ov[0]), 32'd0);
        check("ar_busy",   32'(bz[0]), 32'd0);
        check("ar_iready", 32'(ir[0]), 32'd1);
        check("ar_result", res0, 32'd0);
        next_cycle;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample;
            check("ar_after_vld", 32'(ov[0]), 32'd0);
            next_cycle;
        end

        // Randomised ops/operands on every instance
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom_range(0, 3));
            src1      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            src2      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            next_cycle;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (8) next_cycle;
        sample;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), 32'(rd[k]), 32'(wr[k]));
            check($sformatf("idle%0d", k), 32'(bz[k]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
